// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: 4x4 matrix keypad scanner with press/release debounce,
// PIN entry buffer, display mirror and valid/ready PIN delivery.
//
// Optional feature macro: KEYPAD_TIMEOUT_EN (idle clear of partial entries).
//
// Ports:
//   clk_500Hz, rst_n     scan clock, async active-low reset
//   enable               keypad operational when high
//   JC_cols / JC_rows    active-low column sense / one-hot active-low row drive
//   key_event, key_code  one-cycle pulse per accepted press, with its code
//   pin_data, pin_valid  completed PIN (first digit in MSB nibble), valid flag
//   pin_ready            consumer accept
//   disp_digits          partial entry, unentered slots 4'hF
//   entry_err, timeout   one-cycle pulses on rejected key / idle clear
module keypad_pin_entry #(
  parameter int unsigned PIN_LEN      = 4,
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned TIMEOUT_CYC  = 5000
) (
  input  logic                   clk_500Hz,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [3:0]             JC_cols,
  output logic [3:0]             JC_rows,
  output logic                   key_event,
  output logic [3:0]             key_code,
  output logic [4*PIN_LEN-1:0]   pin_data,
  output logic                   pin_valid,
  input  logic                   pin_ready,
  output logic [4*PIN_LEN-1:0]   disp_digits,
  output logic                   entry_err,
  output logic                   timeout
);

  localparam int unsigned CNT_W  = $clog2(PIN_LEN + 1);
  localparam int unsigned DEB_W  = 16;
  localparam logic [3:0]  K_NONE  = 4'hF;
  localparam logic [3:0]  K_CLEAR = 4'hA;
  localparam logic [3:0]  K_ENTER = 4'hB;
  localparam logic [3:0]  K_DEL   = 4'hC;

  // Elaboration-time parameter range guard
  if (PIN_LEN < 1 || PIN_LEN > 8 || DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 65535 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("keypad_pin_entry: parameter out of range");
  end

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cols_q, sample_row_q;
  logic [3:0]                pat_q, pat_d, pend_q, pend_d, rows_d, code_d;
  logic [DEB_W-1:0]          deb_q, deb_d;
  logic                      key_event_d;
  logic [PIN_LEN-1:0][3:0]   buf_q, buf_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [4*PIN_LEN-1:0]      pin_data_d, disp_d;
  logic                      pin_valid_d, err_d, timeout_d;
  logic                      sample_ok;
`ifdef KEYPAD_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0]         idle_q, idle_d;
`endif

  // Map (driven row, column pattern) to a key code; anything ambiguous is NONE
  function automatic logic [3:0] decode(input logic [3:0] row, input logic [3:0] pat);
    logic [1:0] r, c;
    logic       ok;
    logic [3:0] code;
    ok = 1'b1;
    r  = 2'd0;
    c  = 2'd0;
    case (row)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: ok = 1'b0;
    endcase
    case (pat)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: ok = 1'b0;
    endcase
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'h0;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = K_ENTER;
      4'hE: code = K_CLEAR;
      4'hF: code = K_DEL;
      default: code = K_NONE;
    endcase
    return ok ? code : K_NONE;
  endfunction

  // A column sample is only meaningful if taken while the currently held row was driven
  assign sample_ok = (sample_row_q == JC_rows);

  // Scan / debounce next-state and outputs
  always_comb begin
    state_d     = state_q;
    rows_d      = JC_rows;
    deb_d       = deb_q;
    pat_d       = pat_q;
    pend_d      = pend_q;
    key_event_d = 1'b0;
    code_d      = key_code;
    if (!enable) begin
      state_d = S_SCAN;
      rows_d  = 4'hF;
      deb_d   = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          deb_d = '0;
          if (cols_q != 4'hF && sample_row_q != 4'hF) begin
            // Rows already moved on; step back to the row the press was seen on
            rows_d  = sample_row_q;
            pat_d   = cols_q;
            pend_d  = decode(sample_row_q, cols_q);
            state_d = S_DEBOUNCE;
          end else if (JC_rows == 4'hF) begin
            rows_d = 4'hE;
          end else begin
            rows_d = {JC_rows[2:0], JC_rows[3]};
          end
        end
        S_DEBOUNCE: begin
          if (sample_ok) begin
            if (cols_q == pat_q) begin
              if (deb_q + DEB_W'(1) == DEB_W'(DEBOUNCE_CYC)) begin
                deb_d   = '0;
                state_d = S_HELD;
                if (pend_q != K_NONE) begin
                  key_event_d = 1'b1;
                  code_d      = pend_q;
                end
              end else begin
                deb_d = deb_q + DEB_W'(1);
              end
            end else begin
              deb_d   = '0;
              state_d = S_SCAN;
            end
          end
        end
        S_HELD: begin
          if (sample_ok) begin
            if (cols_q == 4'hF) begin
              if (deb_q + DEB_W'(1) == DEB_W'(DEBOUNCE_CYC)) begin
                deb_d   = '0;
                state_d = S_SCAN;
              end else begin
                deb_d = deb_q + DEB_W'(1);
              end
            end else begin
              deb_d = '0;
            end
          end
        end
        default: state_d = S_SCAN;
      endcase
    end
  end

  // Entry buffer, PIN handshake, display and optional idle clear
  always_comb begin
    buf_d       = buf_q;
    count_d     = count_q;
    pin_valid_d = pin_valid;
    pin_data_d  = pin_data;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    disp_d      = '1;
    if (pin_valid && pin_ready) pin_valid_d = 1'b0;
    if (!enable) begin
      count_d = '0;
    end else if (key_event) begin
      if (key_code <= 4'd9) begin
        if (count_q == CNT_W'(PIN_LEN)) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < PIN_LEN; i++)
            if (CNT_W'(i) == count_q) buf_d[i] = key_code;
          count_d = count_q + CNT_W'(1);
        end
      end else if (key_code == K_CLEAR) begin
        count_d = '0;
      end else if (key_code == K_DEL) begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
      end else if (key_code == K_ENTER && !pin_valid) begin
        if (count_q == CNT_W'(PIN_LEN)) begin
          for (int i = 0; i < PIN_LEN; i++)
            pin_data_d[4*(PIN_LEN-1-i) +: 4] = buf_q[i];
          pin_valid_d = 1'b1;
          count_d     = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
`ifdef KEYPAD_TIMEOUT_EN
    idle_d = idle_q;
    if (!enable || key_event || count_q == '0) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
      idle_d    = '0;
      count_d   = '0;
      timeout_d = 1'b1;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
`endif
    for (int i = 0; i < PIN_LEN; i++)
      if (CNT_W'(i) < count_d) disp_d[4*(PIN_LEN-1-i) +: 4] = buf_d[i];
  end

  // State and output registers
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SCAN;
      cols_q       <= 4'hF;
      sample_row_q <= 4'hF;
      pat_q        <= 4'hF;
      pend_q       <= K_NONE;
      deb_q        <= '0;
      JC_rows      <= 4'b1110;
      key_event    <= 1'b0;
      key_code     <= K_NONE;
      buf_q        <= '1;
      count_q      <= '0;
      pin_data     <= '0;
      pin_valid    <= 1'b0;
      disp_digits  <= '1;
      entry_err    <= 1'b0;
      timeout      <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cols_q       <= JC_cols;
      sample_row_q <= JC_rows;
      pat_q        <= pat_d;
      pend_q       <= pend_d;
      deb_q        <= deb_d;
      JC_rows      <= rows_d;
      key_event    <= key_event_d;
      key_code     <= code_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      pin_data     <= pin_data_d;
      pin_valid    <= pin_valid_d;
      disp_digits  <= disp_d;
      entry_err    <= err_d;
      timeout      <= timeout_d;
`ifdef KEYPAD_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Bench for keypad_pin_entry: behavioural matrix keypad, table of key presses
// with expected buffer/PIN state, plus directed multi-cycle sequences.
module tb_keypad_pin_entry;

  localparam int unsigned PIN_LEN = 4;
  localparam int unsigned DEB     = 3;
  localparam int unsigned TMO     = 50;

  logic        clk_500Hz = 1'b0;
  logic        rst_n, enable, pin_ready;
  logic [3:0]  JC_cols, JC_rows, key_code;
  logic        key_event, pin_valid, entry_err, timeout;
  logic [15:0] pin_data, disp_digits;

  logic        pressed;
  logic [1:0]  prow, pcol;

  int n_vec = 0, n_bad = 0;
  int ev_cnt = 0, err_cnt = 0, tmo_cnt = 0, pv_cycles = 0;
  logic [3:0] last_code = 4'hF;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] disp;
    logic        valid;
    logic [15:0] data;
    int          err;
  } vec_t;
  vec_t vecs[19];

  keypad_pin_entry #(.PIN_LEN(PIN_LEN), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO)) dut (
    .clk_500Hz(clk_500Hz), .rst_n(rst_n), .enable(enable),
    .JC_cols(JC_cols), .JC_rows(JC_rows),
    .key_event(key_event), .key_code(key_code),
    .pin_data(pin_data), .pin_valid(pin_valid), .pin_ready(pin_ready),
    .disp_digits(disp_digits), .entry_err(entry_err), .timeout(timeout)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  // Keypad matrix: pressed switch shorts its column low while its row is driven low
  always_comb begin
    JC_cols = 4'hF;
    if (pressed && JC_rows[prow] == 1'b0) JC_cols[pcol] = 1'b0;
  end

  // Pulse/level monitor, sampling the values that held during the previous cycle
  always @(posedge clk_500Hz) begin
    if (key_event) begin
      ev_cnt    <= ev_cnt + 1;
      last_code <= key_code;
    end
    if (entry_err) err_cnt   <= err_cnt + 1;
    if (timeout)   tmo_cnt   <= tmo_cnt + 1;
    if (pin_valid) pv_cycles <= pv_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic key_pos(input logic [3:0] k, output logic [1:0] r, output logic [1:0] c);
    case (k)
      4'h1: begin r = 0; c = 0; end
      4'h4: begin r = 0; c = 1; end
      4'h7: begin r = 0; c = 2; end
      4'h0: begin r = 0; c = 3; end
      4'h2: begin r = 1; c = 0; end
      4'h5: begin r = 1; c = 1; end
      4'h8: begin r = 1; c = 2; end
      4'h3: begin r = 2; c = 0; end
      4'h6: begin r = 2; c = 1; end
      4'h9: begin r = 2; c = 2; end
      4'hB: begin r = 2; c = 3; end
      4'hA: begin r = 3; c = 2; end
      default: begin r = 3; c = 3; end
    endcase
  endtask

  // Clean press: hold until the event appears (bounded), then release and settle
  task automatic press(input logic [3:0] k);
    bit got;
    key_pos(k, prow, pcol);
    pressed = 1'b1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_500Hz);
      if (key_event) got = 1;
    end
    check("key_event_seen", 32'(got), 32'd1);
    repeat (3) @(negedge clk_500Hz);
    pressed = 1'b0;
    repeat (15) @(negedge clk_500Hz);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rows"},  32'(JC_rows), 32'hE);
    check({tag, "_kev"},   32'(key_event), 32'd0);
    check({tag, "_kcode"}, 32'(key_code), 32'hF);
    check({tag, "_pdata"}, 32'(pin_data), 32'h0);
    check({tag, "_pvld"},  32'(pin_valid), 32'd0);
    check({tag, "_disp"},  32'(disp_digits), 32'hFFFF);
    check({tag, "_err"},   32'(entry_err), 32'd0);
    check({tag, "_tmo"},   32'(timeout), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0, ev0, t0, pv0;
    bit stable;

    vecs[0]  = '{4'h1, 16'h1FFF, 1'b0, 16'h0000, 0};
    vecs[1]  = '{4'h2, 16'h12FF, 1'b0, 16'h0000, 0};
    vecs[2]  = '{4'hB, 16'h12FF, 1'b0, 16'h0000, 1};
    vecs[3]  = '{4'hC, 16'h1FFF, 1'b0, 16'h0000, 0};
    vecs[4]  = '{4'hC, 16'hFFFF, 1'b0, 16'h0000, 0};
    vecs[5]  = '{4'hC, 16'hFFFF, 1'b0, 16'h0000, 0};
    vecs[6]  = '{4'h1, 16'h1FFF, 1'b0, 16'h0000, 0};
    vecs[7]  = '{4'h2, 16'h12FF, 1'b0, 16'h0000, 0};
    vecs[8]  = '{4'h3, 16'h123F, 1'b0, 16'h0000, 0};
    vecs[9]  = '{4'h4, 16'h1234, 1'b0, 16'h0000, 0};
    vecs[10] = '{4'h5, 16'h1234, 1'b0, 16'h0000, 1};
    vecs[11] = '{4'hB, 16'hFFFF, 1'b1, 16'h1234, 0};
    vecs[12] = '{4'h9, 16'h9FFF, 1'b1, 16'h1234, 0};
    vecs[13] = '{4'hB, 16'h9FFF, 1'b1, 16'h1234, 0};
    vecs[14] = '{4'hA, 16'hFFFF, 1'b1, 16'h1234, 0};
    vecs[15] = '{4'h0, 16'h0FFF, 1'b1, 16'h1234, 0};
    vecs[16] = '{4'h7, 16'h07FF, 1'b1, 16'h1234, 0};
    vecs[17] = '{4'h8, 16'h078F, 1'b1, 16'h1234, 0};
    vecs[18] = '{4'h6, 16'h0786, 1'b1, 16'h1234, 0};

    pressed = 1'b0; prow = 0; pcol = 0;
    enable = 1'b1; pin_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk_500Hz);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk_500Hz);

    // Table of presses with expected buffer / PIN state after each
    foreach (vecs[v]) begin
      e0 = err_cnt;
      press(vecs[v].key);
      check($sformatf("v%0d_code", v),  32'(last_code), 32'(vecs[v].key));
      check($sformatf("v%0d_disp", v),  32'(disp_digits), 32'(vecs[v].disp));
      check($sformatf("v%0d_valid", v), 32'(pin_valid), 32'(vecs[v].valid));
      check($sformatf("v%0d_data", v),  32'(pin_data), 32'(vecs[v].data));
      check($sformatf("v%0d_err", v),   32'(err_cnt - e0), 32'(vecs[v].err));
    end

    // PIN held stable under back-pressure, then consumed
    stable = 1;
    repeat (10) begin
      @(negedge clk_500Hz);
      if (pin_data !== 16'h1234 || pin_valid !== 1'b1) stable = 0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    pin_ready = 1'b1;
    @(negedge clk_500Hz);
    pin_ready = 1'b0;
    check("consume_valid", 32'(pin_valid), 32'd0);
    check("consume_data",  32'(pin_data), 32'h1234);

    // Enter loads the retained partial entry as the next PIN
    press(4'hB);
    check("pin2_valid", 32'(pin_valid), 32'd1);
    check("pin2_data",  32'(pin_data), 32'h0786);
    check("pin2_disp",  32'(disp_digits), 32'hFFFF);
    pin_ready = 1'b1;
    @(negedge clk_500Hz);
    check("pin2_consumed", 32'(pin_valid), 32'd0);

    // Ready already high on the load cycle: PIN stays valid for exactly one cycle
    press(4'h4); press(4'h3); press(4'h2); press(4'h1);
    pv0 = pv_cycles;
    press(4'hB);
    check("ready_early_cycles", 32'(pv_cycles - pv0), 32'd1);
    check("ready_early_data",   32'(pin_data), 32'h4321);
    check("ready_early_valid",  32'(pin_valid), 32'd0);
    pin_ready = 1'b0;

    // Bouncing contact, then a long hold: exactly one event
    ev0 = ev_cnt;
    key_pos(4'h8, prow, pcol);
    pressed = 1'b1;
    repeat (6) begin
      @(negedge clk_500Hz);
      pressed = ~pressed;
    end
    pressed = 1'b1;
    repeat (200) @(negedge clk_500Hz);
    pressed = 1'b0;
    repeat (15) @(negedge clk_500Hz);
    check("bounce_events", 32'(ev_cnt - ev0), 32'd1);
    check("bounce_code",   32'(last_code), 32'h8);
    check("bounce_disp",   32'(disp_digits), 32'h8FFF);

    // enable dropped while a key is being debounced
    ev0 = ev_cnt;
    key_pos(4'h5, prow, pcol);
    pressed = 1'b1;
    repeat (2) @(negedge clk_500Hz);
    enable = 1'b0;
    @(negedge clk_500Hz);
    check("dis_rows", 32'(JC_rows), 32'hF);
    repeat (20) @(negedge clk_500Hz);
    check("dis_events", 32'(ev_cnt - ev0), 32'd0);
    check("dis_disp",   32'(disp_digits), 32'hFFFF);
    check("dis_rows_held", 32'(JC_rows), 32'hF);
    pressed = 1'b0;
    enable = 1'b1;
    @(negedge clk_500Hz);
    check("reen_rows", 32'(JC_rows), 32'hE);
    repeat (10) @(negedge clk_500Hz);

    // Idle behaviour after a single digit
    t0 = tmo_cnt;
    press(4'h3);
    check("idle_start_disp", 32'(disp_digits), 32'h3FFF);
    repeat (70) @(negedge clk_500Hz);
`ifdef KEYPAD_TIMEOUT_EN
    check("idle_timeouts", 32'(tmo_cnt - t0), 32'd1);
    check("idle_disp",     32'(disp_digits), 32'hFFFF);
`else
    check("idle_timeouts", 32'(tmo_cnt - t0), 32'd0);
    check("idle_disp",     32'(disp_digits), 32'h3FFF);
`endif

    // Asynchronous reset in the middle of an entry
    press(4'h2);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk_500Hz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_500Hz);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
